// File: rtl/bus_register_bank.sv
// bus_register_bank
// -----------------------------------------------------------------------------
// A bank of DEPTH registers. Each entry has a staged copy and a published copy.
// Any of COUNT bus sources can be written into a staged entry. A commit copies
// every dirty staged entry to its published copy in one cycle. The ALU/memory
// operand fetch reads only the published copies.
//
// Optional feature, off by default:
//   BUS_REGISTER_BANK_ROLLBACK_EN - adds the rollback input. Rollback copies the
//   published value back into each dirty staged entry.
//
// Ports:
//   clock          system clock; all state updates on posedge
//   reset_n        synchronous reset, active-low; clears all state
//   selector       source index; a value >= COUNT (e.g. all-ones) means no write
//   source         packed sources; source i at [i*WIDTH +: WIDTH]
//   write_enable   stage a write this cycle
//   write_address  entry to stage into
//   commit         publish all dirty entries
//   rollback       (optional) discard all dirty staged entries
//   read_address_a read port A entry
//   read_address_b read port B entry
//   read_data_a    registered published value at read_address_a
//   read_data_b    registered published value at read_address_b
//   internal_a     registered staged value at read_address_a
//   dirty          bit k set = staged[k] not yet published
//   dirty_count    registered popcount of dirty
//   commit_done    one-cycle pulse the cycle after a commit edge
module bus_register_bank #(
    parameter int WIDTH = 8,
    parameter int COUNT = 4,
    parameter int DEPTH = 8
) (
    input  logic                         clock,
    input  logic                         reset_n,
    input  logic [$clog2(COUNT+1)-1:0]   selector,
    input  logic [COUNT*WIDTH-1:0]       source,
    input  logic                         write_enable,
    input  logic [$clog2(DEPTH)-1:0]     write_address,
    input  logic                         commit,
`ifdef BUS_REGISTER_BANK_ROLLBACK_EN
    input  logic                         rollback,
`endif
    input  logic [$clog2(DEPTH)-1:0]     read_address_a,
    input  logic [$clog2(DEPTH)-1:0]     read_address_b,
    output logic [WIDTH-1:0]             read_data_a,
    output logic [WIDTH-1:0]             read_data_b,
    output logic [WIDTH-1:0]             internal_a,
    output logic [DEPTH-1:0]             dirty,
    output logic [$clog2(DEPTH+1)-1:0]   dirty_count,
    output logic                         commit_done
);

    localparam int CNT_W = $clog2(DEPTH+1);

    logic [WIDTH-1:0] staged         [DEPTH];
    logic [WIDTH-1:0] published      [DEPTH];
    logic [WIDTH-1:0] staged_next    [DEPTH];
    logic [WIDTH-1:0] published_next [DEPTH];
    logic [DEPTH-1:0] dirty_next;
    logic [WIDTH-1:0] write_data;
    logic             write_accept;

    function automatic logic [CNT_W-1:0] popcount(input logic [DEPTH-1:0] bits);
        logic [CNT_W-1:0] n;
        n = '0;
        for (int k = 0; k < DEPTH; k++) begin
            n = n + CNT_W'(bits[k]);
        end
        return n;
    endfunction

    // Selector is compared and decoded at full integer width, so no index
    // truncation occurs for large COUNT. An out-of-range selector matches no
    // source, and the write is then refused.
    assign write_accept = write_enable && (int'(selector) < COUNT);

    always_comb begin
        write_data = '0;
        for (int i = 0; i < COUNT; i++) begin
            if (int'(selector) == i) begin
                write_data = source[i*WIDTH +: WIDTH];
            end
        end
    end

    // The rules below are applied in priority order: commit, then rollback,
    // then the write. A write in the same cycle therefore always lands in
    // staged and leaves its dirty bit set.
    // NOTE: combinational next-state uses blocking '='; every target gets its
    // default first, so no latch is inferred.
    always_comb begin
        staged_next    = staged;
        published_next = published;
        dirty_next     = dirty;

        if (commit) begin
            for (int k = 0; k < DEPTH; k++) begin
                if (dirty[k]) begin
                    published_next[k] = staged[k];
                end
            end
            dirty_next = '0;
        end
`ifdef BUS_REGISTER_BANK_ROLLBACK_EN
        else if (rollback) begin
            for (int k = 0; k < DEPTH; k++) begin
                if (dirty[k]) begin
                    staged_next[k] = published[k];
                end
            end
            dirty_next = '0;
        end
`endif

        if (write_accept) begin
            staged_next[write_address] = write_data;
            dirty_next[write_address]  = 1'b1;
        end
    end

    // Reads sample the arrays as they were before this edge. A read on a
    // commit edge therefore returns the old published value, and internal_a
    // on a write edge returns the old staged value.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            // NOTE: both arrays are cleared on reset on purpose. A reset must
            // discard staged data, and published must read back as zero.
            for (int k = 0; k < DEPTH; k++) begin
                staged[k]    <= '0;
                published[k] <= '0;
            end
            dirty       <= '0;
            dirty_count <= '0;
            commit_done <= 1'b0;
            read_data_a <= '0;
            read_data_b <= '0;
            internal_a  <= '0;
        end else begin
            // NOTE: sequential state uses non-blocking '<=' so that every read
            // in this block sees the value from before the edge.
            staged      <= staged_next;
            published   <= published_next;
            dirty       <= dirty_next;
            dirty_count <= popcount(dirty_next);
            commit_done <= commit;
            read_data_a <= published[read_address_a];
            read_data_b <= published[read_address_b];
            internal_a  <= staged[read_address_a];
        end
    end

endmodule

// File: tb/tb_bus_register_bank.sv
// Table-driven bench for bus_register_bank with the default parameters
// (WIDTH=8, COUNT=4, DEPTH=8). Each record holds the inputs for one clock edge
// and the outputs expected just after that edge. The expected outputs are
// derived by hand from the behaviour of the bank.
module tb_bus_register_bank;

    logic        clock = 1'b0;
    logic        reset_n;
    logic [2:0]  selector;
    logic [31:0] source;
    logic        write_enable;
    logic [2:0]  write_address;
    logic        commit;
`ifdef BUS_REGISTER_BANK_ROLLBACK_EN
    logic        rollback;
`endif
    logic [2:0]  read_address_a;
    logic [2:0]  read_address_b;
    logic [7:0]  read_data_a;
    logic [7:0]  read_data_b;
    logic [7:0]  internal_a;
    logic [7:0]  dirty;
    logic [3:0]  dirty_count;
    logic        commit_done;

    bus_register_bank #(.WIDTH(8), .COUNT(4), .DEPTH(8)) dut (
        .clock          (clock),
        .reset_n        (reset_n),
        .selector       (selector),
        .source         (source),
        .write_enable   (write_enable),
        .write_address  (write_address),
        .commit         (commit),
`ifdef BUS_REGISTER_BANK_ROLLBACK_EN
        .rollback       (rollback),
`endif
        .read_address_a (read_address_a),
        .read_address_b (read_address_b),
        .read_data_a    (read_data_a),
        .read_data_b    (read_data_b),
        .internal_a     (internal_a),
        .dirty          (dirty),
        .dirty_count    (dirty_count),
        .commit_done    (commit_done)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic        rst_n;
        logic        we;
        logic [2:0]  sel;
        logic [2:0]  wa;
        logic [31:0] src;
        logic        cm;
        logic        rb;
        logic [2:0]  ra;
        logic [2:0]  rbad;
        logic [7:0]  e_rda;
        logic [7:0]  e_rdb;
        logic [7:0]  e_int;
        logic [7:0]  e_dirty;
        logic [3:0]  e_cnt;
        logic        e_done;
    } vec_t;

    vec_t vecs[$];
    vec_t exp_q[$];
    int   n_vectors = 0;
    int   n_miscompares = 0;

    function automatic vec_t mk(
        input logic rst_n, input logic we, input logic [2:0] sel,
        input logic [2:0] wa, input logic [31:0] src, input logic cm,
        input logic rb, input logic [2:0] ra, input logic [2:0] rbad,
        input logic [7:0] e_rda, input logic [7:0] e_rdb, input logic [7:0] e_int,
        input logic [7:0] e_dirty, input logic [3:0] e_cnt, input logic e_done);
        vec_t v;
        v.rst_n = rst_n; v.we = we; v.sel = sel; v.wa = wa; v.src = src;
        v.cm = cm; v.rb = rb; v.ra = ra; v.rbad = rbad;
        v.e_rda = e_rda; v.e_rdb = e_rdb; v.e_int = e_int;
        v.e_dirty = e_dirty; v.e_cnt = e_cnt; v.e_done = e_done;
        return v;
    endfunction

    // Idle step: no write, no commit, selector set to "no source".
    function automatic vec_t idle(
        input logic [2:0] ra, input logic [2:0] rbad,
        input logic [7:0] e_rda, input logic [7:0] e_rdb, input logic [7:0] e_int,
        input logic [7:0] e_dirty, input logic [3:0] e_cnt);
        return mk(1, 0, 3'd7, 3'd0, 32'h0, 0, 0, ra, rbad,
                  e_rda, e_rdb, e_int, e_dirty, e_cnt, 0);
    endfunction

    task automatic check(input string name, input int idx,
                         input logic [7:0] got, input logic [7:0] want);
        if (got !== want) begin
            n_miscompares++;
            $display("FAIL vec%0d %s: got 0x%0h, want 0x%0h", idx, name, got, want);
        end
    endtask

    // Drive the inputs and push the record onto the scoreboard. After the
    // edge, pop the record and compare the registered outputs.
    task automatic apply(input int idx, input vec_t v);
        vec_t e;
        reset_n        = v.rst_n;
        write_enable   = v.we;
        selector       = v.sel;
        write_address  = v.wa;
        source         = v.src;
        commit         = v.cm;
`ifdef BUS_REGISTER_BANK_ROLLBACK_EN
        rollback       = v.rb;
`endif
        read_address_a = v.ra;
        read_address_b = v.rbad;
        exp_q.push_back(v);
        @(posedge clock);
        #1;
        e = exp_q.pop_front();
        n_vectors++;
        check("read_data_a", idx, read_data_a, e.e_rda);
        check("read_data_b", idx, read_data_b, e.e_rdb);
        check("internal_a",  idx, internal_a,  e.e_int);
        check("dirty",       idx, dirty,       e.e_dirty);
        check("dirty_count", idx, {4'h0, dirty_count}, {4'h0, e.e_cnt});
        check("commit_done", idx, {7'h0, commit_done}, {7'h0, e.e_done});
        @(negedge clock);
    endtask

    initial begin
        // Reset for two cycles, with a write and a commit requested.
        vecs.push_back(mk(0, 1, 3'd0, 3'd0, 32'h11223344, 1, 0, 0, 0, 0, 0, 0, 8'h00, 0, 0));
        vecs.push_back(mk(0, 1, 3'd0, 3'd0, 32'h11223344, 1, 0, 0, 0, 0, 0, 0, 8'h00, 0, 0));
        // Stage source 2 (0xA5) into entry 3, then publish it.
        vecs.push_back(mk(1, 1, 3'd2, 3'd3, 32'h00A50000, 0, 0, 3, 3, 8'h00, 8'h00, 8'h00, 8'h08, 1, 0));
        vecs.push_back(idle(3, 3, 8'h00, 8'h00, 8'hA5, 8'h08, 1));
        vecs.push_back(mk(1, 0, 3'd7, 3'd0, 32'h0, 1, 0, 3, 3, 8'h00, 8'h00, 8'hA5, 8'h00, 0, 1));
        vecs.push_back(idle(3, 3, 8'hA5, 8'hA5, 8'hA5, 8'h00, 0));
        // Writes with selector 7, 4 and 5 must be ignored.
        vecs.push_back(mk(1, 1, 3'd7, 3'd5, 32'hDEADBEEF, 0, 0, 5, 3, 8'h00, 8'hA5, 8'h00, 8'h00, 0, 0));
        vecs.push_back(mk(1, 1, 3'd4, 3'd5, 32'hDEADBEEF, 0, 0, 5, 3, 8'h00, 8'hA5, 8'h00, 8'h00, 0, 0));
        vecs.push_back(mk(1, 1, 3'd5, 3'd5, 32'hDEADBEEF, 0, 0, 5, 3, 8'h00, 8'hA5, 8'h00, 8'h00, 0, 0));
        vecs.push_back(idle(5, 5, 8'h00, 8'h00, 8'h00, 8'h00, 0));
        // Write and commit on the same edge. The commit publishes 0x11 and the
        // new value 0x22 stays staged and dirty.
        vecs.push_back(mk(1, 1, 3'd0, 3'd1, 32'h00000011, 0, 0, 1, 1, 8'h00, 8'h00, 8'h00, 8'h02, 1, 0));
        vecs.push_back(mk(1, 1, 3'd1, 3'd1, 32'h00002200, 1, 0, 1, 1, 8'h00, 8'h00, 8'h11, 8'h02, 1, 1));
        vecs.push_back(idle(1, 1, 8'h11, 8'h11, 8'h22, 8'h02, 1));
        // Back-to-back commits; the second one has no dirty entries.
        vecs.push_back(mk(1, 0, 3'd7, 3'd0, 32'h0, 1, 0, 1, 3, 8'h11, 8'hA5, 8'h22, 8'h00, 0, 1));
        vecs.push_back(mk(1, 0, 3'd7, 3'd0, 32'h0, 1, 0, 1, 3, 8'h22, 8'hA5, 8'h22, 8'h00, 0, 1));
        vecs.push_back(idle(1, 3, 8'h22, 8'hA5, 8'h22, 8'h00, 0));
        // Fill every entry, rotating through all four sources.
        for (int k = 0; k < 8; k++) begin
            logic [31:0] s;
            logic [7:0]  old;
            s = 32'h0;
            s[(k % 4) * 8 +: 8] = 8'(8'h10 + k);
            old = (k == 1) ? 8'h22 : (k == 3) ? 8'hA5 : 8'h00;
            vecs.push_back(mk(1, 1, 3'(k % 4), 3'(k), s, 0, 0, 3'(k), 3'(k),
                              old, old, old, 8'((16'h1 << (k + 1)) - 16'h1), 4'(k + 1), 0));
        end
        vecs.push_back(mk(1, 0, 3'd7, 3'd0, 32'h0, 1, 0, 0, 7, 8'h00, 8'h00, 8'h10, 8'h00, 0, 1));
        for (int k = 0; k < 8; k++) begin
            vecs.push_back(idle(3'(k), 3'(7 - k), 8'(8'h10 + k), 8'(8'h17 - k),
                                8'(8'h10 + k), 8'h00, 0));
        end
        // A reset in the middle of a sequence discards the staged 0x77.
        vecs.push_back(mk(1, 1, 3'd3, 3'd2, 32'h77000000, 0, 0, 2, 2, 8'h12, 8'h12, 8'h12, 8'h04, 1, 0));
        vecs.push_back(mk(0, 0, 3'd7, 3'd0, 32'h0, 1, 0, 2, 2, 8'h00, 8'h00, 8'h00, 8'h00, 0, 0));
        vecs.push_back(idle(2, 2, 8'h00, 8'h00, 8'h00, 8'h00, 0));
        vecs.push_back(mk(1, 0, 3'd7, 3'd0, 32'h0, 1, 0, 2, 2, 8'h00, 8'h00, 8'h00, 8'h00, 0, 1));
        vecs.push_back(idle(2, 2, 8'h00, 8'h00, 8'h00, 8'h00, 0));
`ifdef BUS_REGISTER_BANK_ROLLBACK_EN
        // Publish 0x33 to entry 4, stage 0x44 there, then roll it back.
        vecs.push_back(mk(1, 1, 3'd0, 3'd4, 32'h00000033, 0, 0, 4, 4, 8'h00, 8'h00, 8'h00, 8'h10, 1, 0));
        vecs.push_back(mk(1, 0, 3'd7, 3'd0, 32'h0, 1, 0, 4, 4, 8'h00, 8'h00, 8'h33, 8'h00, 0, 1));
        vecs.push_back(mk(1, 1, 3'd0, 3'd4, 32'h00000044, 0, 0, 4, 4, 8'h33, 8'h33, 8'h33, 8'h10, 1, 0));
        vecs.push_back(mk(1, 0, 3'd7, 3'd0, 32'h0, 0, 1, 4, 4, 8'h33, 8'h33, 8'h44, 8'h00, 0, 0));
        vecs.push_back(idle(4, 4, 8'h33, 8'h33, 8'h33, 8'h00, 0));
        // Rollback together with commit: the commit takes priority.
        vecs.push_back(mk(1, 1, 3'd0, 3'd4, 32'h00000044, 0, 0, 4, 4, 8'h33, 8'h33, 8'h33, 8'h10, 1, 0));
        vecs.push_back(mk(1, 0, 3'd7, 3'd0, 32'h0, 1, 1, 4, 4, 8'h33, 8'h33, 8'h44, 8'h00, 0, 1));
        vecs.push_back(idle(4, 4, 8'h44, 8'h44, 8'h44, 8'h00, 0));
        // Rollback together with a write: the rollback restores entry 5, and
        // the write to entry 6 is still staged and marked dirty.
        vecs.push_back(mk(1, 1, 3'd1, 3'd5, 32'h00005500, 0, 0, 5, 4, 8'h00, 8'h44, 8'h00, 8'h20, 1, 0));
        vecs.push_back(mk(1, 1, 3'd2, 3'd6, 32'h00660000, 0, 1, 5, 6, 8'h00, 8'h00, 8'h55, 8'h40, 1, 0));
        vecs.push_back(idle(5, 6, 8'h00, 8'h00, 8'h00, 8'h40, 1));
`endif

        foreach (vecs[i]) begin
            apply(i, vecs[i]);
        end
        if (exp_q.size() != 0) begin
            n_miscompares++;
            $display("FAIL scoreboard: got %0d entries left, want 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vectors, n_miscompares);
        $finish;
    end

endmodule

// File: doc/bus_register_bank.md
Name: bus_register_bank

Overview:
- Parametrised successor to the single bus register: a bank of DEPTH registers, each loadable from any of COUNT bus sources.
- Two-level storage per entry. A staged copy takes bus writes; a published copy drives the rest of the datapath.
- An explicit commit moves all dirty staged entries to published in one atomic cycle. Dirty tracking and a pending count support the control sequencer.
- Sits between the source bus and the ALU/memory operand fetch; replaces banks of individual bus registers.

Parameters:
WIDTH, 8, data width of every source and register entry
COUNT, 4, number of bus sources packed in source
DEPTH, 8, number of register entries (power of two, >= 2)

Ports:
clock  input  1  single system clock; all state updates on posedge
reset_n  input  1  synchronous reset, active-low
selector  input  $clog2(COUNT+1)  source index; all-ones = no write
source  input  COUNT*WIDTH  packed sources, source index i at bits [i*WIDTH +: WIDTH]
write_enable  input  1  stage a write this cycle
write_address  input  $clog2(DEPTH)  entry to stage into
commit  input  1  publish all dirty entries
read_address_a  input  $clog2(DEPTH)  read port A entry
read_address_b  input  $clog2(DEPTH)  read port B entry
read_data_a  output  WIDTH  registered published value, port A
read_data_b  output  WIDTH  registered published value, port B
internal_a  output  WIDTH  registered staged value at read_address_a
dirty  output  DEPTH  bit k set = staged[k] differs in origin from published[k]
dirty_count  output  $clog2(DEPTH+1)  popcount of dirty, registered
commit_done  output  1  one-cycle pulse the cycle after a commit edge

Behaviour:
- Reset: on a posedge with reset_n=0, the following all go to 0:
  - staged and published arrays
  - read_data_a/b, internal_a
  - dirty, dirty_count, commit_done
- Reset overrides write, commit and rollback in the same cycle. Reset mid-sequence discards all staged data.
- Write acceptance: requires write_enable=1 and selector < COUNT.
  - selector all-ones, or any value >= COUNT: no write, dirty unchanged.
  - Accepted write: staged[write_address] <= source[selector*WIDTH +: WIDTH]; dirty[write_address] <= 1.
- Commit: at a posedge with commit=1, published[k] <= staged[k] for every k with dirty[k]=1. Those dirty bits clear. commit_done=1 for the following cycle only.
- Commit with no dirty entries still pulses commit_done and leaves published unchanged.
- Write + commit same cycle:
  - Commit publishes the staged values held before the edge.
  - The new write lands in staged and leaves its dirty bit set, including when the write targets an entry being committed.
- Back-to-back commits: each commit pulses commit_done one cycle later, so the pulse stays high continuously.
- Reads: read_data_a/b <= published[read_address_x] each posedge, giving 1-cycle latency.
  - A read sampled on the same edge as a commit returns the pre-commit published value.
  - Both ports may address the same entry.
- internal_a <= staged[read_address_a], 1-cycle latency. It returns the pre-write value on the write edge.
- dirty_count: registered, consistent with dirty after the same edge; reaches DEPTH when all entries are dirty, with no saturation issue.
- Index arithmetic: part-select indices are computed at the width of the index port plus WIDTH scaling; no truncation for COUNT up to 2^16.

Optional Feature:
- Macro: BUS_REGISTER_BANK_ROLLBACK_EN.
- Enabled:
  - Adds input port rollback (1 bit).
  - At a posedge with rollback=1, staged[k] <= published[k] for all dirty k and all dirty bits clear.
  - rollback together with commit: commit wins and rollback is ignored.
  - rollback together with an accepted write: rollback applies first, then the write is staged and its dirty bit is set.
- Disabled: the port does not exist and staged data can only be overwritten or committed.

Test Plan:
- Reset: reset_n=0 for 2 cycles with write_enable=1 and commit=1 -> all outputs 0, dirty=0, dirty_count=0.
- Stage and publish: COUNT=4, source[2]=0xA5, selector=2, write_address=3, write_enable=1.
  - Next cycle: dirty=0x08, internal_a(addr 3)=0xA5, read_data_a=0x00.
  - Then commit: commit_done pulses, dirty=0, read_data_a=0xA5 one cycle after.
- Ignored writes: selector=3'b111, then selector=4 (COUNT=4), each with write_enable=1 -> staged and dirty unchanged, dirty_count stays 0.
- Write + commit collision: entry 1 staged 0x11 and dirty; the same edge writes 0x22 to entry 1 and commits.
  - published[1]=0x11, staged[1]=0x22, dirty[1]=1, dirty_count=1.
- Fill all: write entries 0..7 with 0x10+k -> dirty=0xFF, dirty_count=8; commit -> both read ports return 0x10+k for every k.
- Rollback (macro on): published[4]=0x33, stage 0x44 into entry 4, assert rollback -> internal_a(addr 4)=0x33, dirty=0; rollback with commit -> published[4]=0x44.
